// File: rtl/mips_cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// mips_cpu_run_ctrl
//
// Run/halt and stall controller for the MIPS core. It produces the core-wide
// clock enable (clken) and tracks the halt sequence: a jr $0 retires, its
// branch delay slot retires, and then the core stops. It freezes the core
// while a memory wait-request or a multi-cycle unit is busy. It faults if a
// stall lasts too long.
//
// Parameters:
//   HALT_INSTR   instruction word that requests halt (jr $0)
//   WAIT_TIMEOUT consecutive stalled cycles before fault (0 = never fault)
//   CNT_W        width of the performance counters
//
// Ports:
//   clk               in   system clock
//   reset             in   synchronous active-high reset (next state RUN)
//   clk_enable        in   external run gate; low freezes this block
//   instr_readdata    in   [31:0] currently fetched instruction
//   instr_waitrequest in   instruction memory not ready
//   data_read         in   core data read request
//   data_write        in   core data write request
//   data_waitrequest  in   data memory not ready
//   stall_req         in   mul/div unit busy
//   clken             out  core state-element enable (combinational)
//   active            out  core running (registered)
//   fault             out  wait-request timeout occurred (registered, sticky)
//   cycle_count       out  [CNT_W-1:0] enabled run cycles since reset
//   instr_count       out  [CNT_W-1:0] retired instructions since reset
//
// Build option: define RUN_CTRL_PERF_EN to implement cycle_count and
// instr_count. Without it both outputs are tied to zero.
// -----------------------------------------------------------------------------
module mips_cpu_run_ctrl #(
  parameter logic [31:0] HALT_INSTR   = 32'h0000_0008,
  parameter int          WAIT_TIMEOUT = 64,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic [31:0]      instr_readdata,
  input  logic             instr_waitrequest,
  input  logic             data_read,
  input  logic             data_write,
  input  logic             data_waitrequest,
  input  logic             stall_req,
  output logic             clken,
  output logic             active,
  output logic             fault,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  // A zero timeout still needs a legal (1-bit) counter.
  localparam int SC_W = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
  // Counter value at which one more stalled cycle means timeout.
  localparam logic [SC_W-1:0] SC_LAST = (WAIT_TIMEOUT > 0) ? SC_W'(WAIT_TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_SLOT,
    S_HALTED,
    S_FAULT
  } state_t;

  // Power-up values hold the block idle until the first reset.
  state_t          r_state     = S_IDLE;
  logic            r_active    = 1'b0;
  logic            r_fault     = 1'b0;
  logic [SC_W-1:0] r_stall_cnt = '0;

  state_t w_state_next;
  logic   w_stall;
  logic   w_running;
  logic   w_clken;
  logic   w_timeout;

  assign w_stall   = instr_waitrequest | ((data_read | data_write) & data_waitrequest) | stall_req;
  assign w_running = (r_state == S_RUN) || (r_state == S_SLOT);
  // Critical enable path: a single AND of the gate, reset, run state and stall.
  assign w_clken   = clk_enable & ~reset & w_running & ~w_stall;
  assign w_timeout = (WAIT_TIMEOUT != 0) && clk_enable && w_running && w_stall
                     && (r_stall_cnt == SC_LAST);

  // Next-state logic. Reset is applied in the state register.
  always_comb begin
    w_state_next = r_state;
    if (clk_enable) begin
      unique case (r_state)
        S_RUN: begin
          if (w_timeout)
            w_state_next = S_FAULT;
          else if (w_clken && (instr_readdata == HALT_INSTR))
            w_state_next = S_SLOT;
        end
        S_SLOT: begin
          // Any instruction in the delay slot, including another jr $0,
          // completes the halt.
          if (w_timeout)
            w_state_next = S_FAULT;
          else if (w_clken)
            w_state_next = S_HALTED;
        end
        default: w_state_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_RUN;
      r_active <= 1'b1;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_active <= (w_state_next == S_RUN) || (w_state_next == S_SLOT);
      if (w_timeout)
        r_fault <= 1'b1;
    end
  end

  // Consecutive stalled-cycle counter. It saturates rather than wrapping, so
  // a disabled timeout cannot alias back to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (clk_enable) begin
      if (!w_stall)
        r_stall_cnt <= '0;
      else if (w_running && !(&r_stall_cnt))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

`ifdef RUN_CTRL_PERF_EN
  logic [CNT_W-1:0] r_cycle_cnt = '0;
  logic [CNT_W-1:0] r_instr_cnt = '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      if (clk_enable && w_running && !(&r_cycle_cnt))
        r_cycle_cnt <= r_cycle_cnt + 1'b1;
      if (w_clken && !(&r_instr_cnt))
        r_instr_cnt <= r_instr_cnt + 1'b1;
    end
  end

  assign cycle_count = r_cycle_cnt;
  assign instr_count = r_instr_cnt;
`else
  assign cycle_count = '0;
  assign instr_count = '0;
`endif

  assign clken  = w_clken;
  assign active = r_active;
  assign fault  = r_fault;

endmodule
